// File: rtl/ccip_pipe_skid.sv
// ccip_pipe_skid: STAGES-deep register slice for one CCI-P Tx request
// channel, with pipelined almost-full and a skid FIFO for in-flight requests.
//
// Ports:
//   pClk, pck_cp2af_softReset_n     clock, async active-low reset
//   up_valid, up_data, up_almfull   AFU-core side (request in, back-pressure out)
//   dn_valid, dn_data, dn_almfull   FIU side (request out, back-pressure in)
//   ovf_err                         sticky: FIFO write attempted while full
//   occupancy                       current skid FIFO count
//   stat_clr, stat_hwm,
//   stat_stall_cyc                  only when CCIP_PIPE_STATS_EN is defined
//
// Build option: define CCIP_PIPE_STATS_EN to add the statistics counters.
module ccip_pipe_skid #(
  parameter int DATA_W   = 552,
  parameter int STAGES   = 2,
  parameter int DEPTH    = 16,
  parameter int UP_SLACK = 8
) (
  input  logic                     pClk,
  input  logic                     pck_cp2af_softReset_n,
  input  logic                     up_valid,
  input  logic [DATA_W-1:0]        up_data,
  output logic                     up_almfull,
  output logic                     dn_valid,
  output logic [DATA_W-1:0]        dn_data,
  input  logic                     dn_almfull,
  output logic                     ovf_err,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef CCIP_PIPE_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [$clog2(DEPTH):0]   stat_hwm,
  output logic [31:0]              stat_stall_cyc
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int THRESH = DEPTH - STAGES - UP_SLACK;

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("ccip_pipe_skid: STAGES must be 1..8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ccip_pipe_skid: DEPTH must be a power of 2");
  end
  if (DEPTH <= STAGES + UP_SLACK) begin : g_bad_slack
    $error("ccip_pipe_skid: DEPTH must exceed STAGES+UP_SLACK");
  end

  logic rst_n;
  assign rst_n = pck_cp2af_softReset_n;

  // ---------------- forward request pipe ----------------
  logic [STAGES-1:0] fv_q;
  logic [DATA_W-1:0] fd_q [STAGES];

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q <= '0;
    end else begin
      fv_q[0] <= up_valid;
      for (int i = 1; i < STAGES; i++) begin
        fv_q[i] <= fv_q[i-1];
      end
    end
  end

  always_ff @(posedge pClk) begin
    fd_q[0] <= up_data;
    for (int i = 1; i < STAGES; i++) begin
      fd_q[i] <= fd_q[i-1];
    end
  end

  // ---------------- skid FIFO ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              drop;

  assign push_req = fv_q[STAGES-1];
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop      = (cnt_q != '0) && !dn_almfull;
  // A full FIFO still accepts a write when the head leaves this cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge pClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fd_q[STAGES-1];
    end
  end

  // ---------------- output register ----------------
  logic              dn_valid_q;
  logic [DATA_W-1:0] dn_data_q;
  logic              ovf_q;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dn_valid_q <= pop;
      ovf_q      <= ovf_q | drop;
    end
  end

  always_ff @(posedge pClk) begin
    if (pop) begin
      dn_data_q <= mem_q[rd_ptr_q];
    end
  end

  // ---------------- almost-full back-pressure ----------------
  // Everything already committed downstream of the AFU counts against
  // the FIFO: stored entries plus requests still in the forward pipe.
  logic [31:0]       pend;
  logic              af_raw;
  logic [STAGES-1:0] af_q;

  always_comb begin
    pend = 32'(cnt_q);
    for (int i = 0; i < STAGES; i++) begin
      pend = pend + 32'(fv_q[i]);
    end
  end

  assign af_raw = (pend >= 32'(THRESH));

  // Resets closed so the AFU holds off until the pipe has settled.
  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= '1;
    end else begin
      af_q[0] <= af_raw;
      for (int i = 1; i < STAGES; i++) begin
        af_q[i] <= af_q[i-1];
      end
    end
  end

  assign up_almfull = af_q[STAGES-1];
  assign dn_valid   = dn_valid_q;
  assign dn_data    = dn_data_q;
  assign ovf_err    = ovf_q;
  assign occupancy  = cnt_q;

`ifdef CCIP_PIPE_STATS_EN
  // ---------------- statistics ----------------
  logic [CW-1:0] hwm_q;
  logic [31:0]   stall_q;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else if (stat_clr) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (cnt_q > hwm_q) begin
        hwm_q <= cnt_q;
      end
      if ((cnt_q != '0) && dn_almfull && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_hwm       = hwm_q;
  assign stat_stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_ccip_pipe_skid.sv
// Testbench for ccip_pipe_skid: random and directed traffic checked by a
// queue-based reference model and a scoreboard monitor.
module tb_ccip_pipe_skid;

  localparam int DW     = 552;
  localparam int STG    = 2;
  localparam int DEP    = 16;
  localparam int SLK    = 8;
  localparam int CWB    = $clog2(DEP) + 1;
  localparam int THR    = DEP - STG - SLK;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            up_valid;
  logic [DW-1:0]   up_data;
  logic            up_almfull;
  logic            dn_valid;
  logic [DW-1:0]   dn_data;
  logic            dn_almfull;
  logic            ovf_err;
  logic [CWB-1:0]  occupancy;
`ifdef CCIP_PIPE_STATS_EN
  logic            stat_clr = 1'b0;
  logic [CWB-1:0]  stat_hwm;
  logic [31:0]     stat_stall_cyc;
`endif

  always #5 clk = ~clk;

  ccip_pipe_skid #(
    .DATA_W(DW), .STAGES(STG), .DEPTH(DEP), .UP_SLACK(SLK)
  ) dut (
    .pClk(clk),
    .pck_cp2af_softReset_n(rst_n),
    .up_valid(up_valid),
    .up_data(up_data),
    .up_almfull(up_almfull),
    .dn_valid(dn_valid),
    .dn_data(dn_data),
    .dn_almfull(dn_almfull),
    .ovf_err(ovf_err),
    .occupancy(occupancy)
`ifdef CCIP_PIPE_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_hwm(stat_hwm),
    .stat_stall_cyc(stat_stall_cyc)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 18; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Requests are tracked by the edge that sampled them; a request joins
  // the buffer STG edges later, the buffer drains one per open edge.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } pitem_t;

  pitem_t        pipeq[$];
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] sb[$];
  bit            raw_hist[$];
  int            n;
  bit            exp_dv, exp_af, exp_ovf;
  int            exp_occ;

  function automatic void model_reset();
    pipeq.delete(); fifo.delete(); sb.delete(); raw_hist.delete();
    raw_hist.push_back(1'b0);
    n = 0; exp_dv = 0; exp_af = 1; exp_ovf = 0; exp_occ = 0;
  endfunction

  function automatic void model_step();
    bit pop;
    pitem_t it;
    n++;
    pop = (fifo.size() > 0) && !dn_almfull;
    exp_dv = pop;
    if (pop) sb.push_back(fifo.pop_front());
    if (pipeq.size() > 0 && pipeq[0].t == n - STG) begin
      it = pipeq.pop_front();
      if (fifo.size() == DEP) exp_ovf = 1;
      else fifo.push_back(it.d);
    end
    if (up_valid) begin
      it.d = up_data; it.t = n;
      pipeq.push_back(it);
    end
    raw_hist.push_back((fifo.size() + pipeq.size()) >= THR);
    exp_af  = (n < STG) ? 1'b1 : raw_hist[n-STG];
    exp_occ = fifo.size();
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  int out_cnt = 0;
  int max_occ = 0;
  logic [DW-1:0] expd;

  initial begin
    forever begin
      @(negedge clk);
      chk("dn_valid", dn_valid, exp_dv);
      chk("occupancy", occupancy, exp_occ);
      chk("up_almfull", up_almfull, exp_af);
      chk("ovf_err", ovf_err, exp_ovf);
      if (occupancy > max_occ) max_occ = occupancy;
      if (dn_valid === 1'b1) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          expd = sb.pop_front();
          chkd("dn_data", dn_data, expd);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || fifo.size() != 0 || pipeq.size() != 0 ||
            dn_valid) && k < 500) begin
      step();
      k++;
    end
    chk("drain_done", k < 500, 1);
  endtask

  int k, lat, first, last, cnt, n_iss;
  bit af_seen;

  initial begin
    rst_n = 1'b1; up_valid = 0; up_data = '0; dn_almfull = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_up_almfull", up_almfull, 1);
    chk("rst_ovf", ovf_err, 0);
    rst_n = 1'b1;
    k = 0;
    while (up_almfull && k < 20) begin step(); k++; end
    chk("rst_release_af", (k >= 1 && k <= STG + 1), 1);

    // latency
    up_valid = 1; up_data = DW'(8'hA5);
    step();
    up_valid = 0;
    lat = 1;
    while (!dn_valid && lat < 20) begin step(); lat++; end
    chk("latency", lat, STG + 2);
    chkd("latency_data", dn_data, DW'(8'hA5));
    step();
    chk("latency_occ0", occupancy, 0);

    // back-to-back stream
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          up_valid = 1; up_data = DW'(i + 1000);
          step();
        end
        up_valid = 0;
      end
      begin
        first = -1; last = -1; cnt = 0; af_seen = 0;
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (dn_valid) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
          end
          af_seen |= up_almfull;
        end
      end
    join
    chk("stream_cnt", cnt, 100);
    chk("stream_gapless", last - first, 99);
    chk("stream_af_seen", af_seen, 0);

    // backpressure with well-behaved upstream
    dn_almfull = 1; n_iss = 0; max_occ = 0;
    while (!up_almfull && n_iss < 40) begin
      up_valid = 1; up_data = rnd();
      step();
      n_iss++;
    end
    chk("bp_issue_before_af", n_iss, THR + STG);
    for (int i = 0; i < SLK; i++) begin
      up_valid = 1; up_data = rnd();
      step();
    end
    up_valid = 0;
    repeat (4) step();
    chk("bp_peak_occ", max_occ, DEP);
    chk("bp_no_ovf", ovf_err, 0);
    dn_almfull = 0;
    drain();
    repeat (4) step();

    // threshold timing
    dn_almfull = 1;
    for (int i = 0; i < THR - 1; i++) begin
      up_valid = 1; up_data = rnd();
      step();
    end
    up_valid = 0;
    repeat (6) step();
    chk("thr_below", up_almfull, 0);
    up_valid = 1; up_data = rnd();
    step();
    up_valid = 0;
    k = 0;
    while (!up_almfull && k < 10) begin step(); k++; end
    chk("thr_rise", k, STG);
    dn_almfull = 0;
    step();
    k = 0;
    while (up_almfull && k < 10) begin step(); k++; end
    chk("thr_fall", k, STG);
    drain();
    repeat (4) step();

    // overflow: upstream ignores almost-full
    dn_almfull = 1;
    for (int i = 0; i < DEP + 1; i++) begin
      up_valid = 1; up_data = rnd();
      step();
    end
    up_valid = 0;
    repeat (4) step();
    chk("ovf_set", ovf_err, 1);
    chk("ovf_occ", occupancy, DEP);
    out_cnt = 0;
    dn_almfull = 0;
    drain();
    chk("ovf_drain_cnt", out_cnt, DEP);
    chk("ovf_sticky", ovf_err, 1);

    // reset mid-burst
    dn_almfull = 1;
    for (int i = 0; i < 10; i++) begin
      up_valid = 1; up_data = rnd();
      step();
    end
    up_valid = 0;
    repeat (3) step();
    chk("mid_occ10", occupancy, 10);
    dn_almfull = 0;
    step();
    chk("mid_dv_before", dn_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", dn_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_af", up_almfull, 1);
    chk("mid_rst_ovf", ovf_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    k = 0;
    while (up_almfull && k < 20) begin step(); k++; end
    chk("mid_release_af", (k >= 1 && k <= STG + 1), 1);

    // random traffic, upstream honours almost-full
    for (int c = 0; c < 3000; c++) begin
      dn_almfull = (c % 400 < 200) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
      up_valid = !up_almfull && ($urandom_range(0, 2) != 0);
      up_data = rnd();
      step();
    end
    up_valid = 0;
    dn_almfull = 0;
    drain();
    chk("rand_no_ovf", ovf_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
